core_boot_ctrl: RTL and testbench
=================================

CORE_BOOT_CTRL -- requirements
Module: core_boot_ctrl

Interface
REQ-001 SHALL have parameters: ADDR_W, default 16, icache address width; INSTR_W, default 60, instruction word width; RUN_W, default 16, run-cycle counter width; RST_LEN, default 2, core reset pulse length in cycles (>=1).
REQ-002 SHALL use one clock; reset is synchronous and active-high.
REQ-003 SHALL have these ports (name  direction  width  meaning):
- clock_i  in  1  sole clock, rising edge.
- reset_i  in  1  synchronous active-high reset.
- start_i  in  1  begin a load/run session.
- abort_i  in  1  cancel the session and return to IDLE.
- autoInc_i  in  1  1 = sequential addressing from baseAddress_i; 0 = explicit loadAddress_i.
- baseAddress_i  in  ADDR_W  first address in auto-increment mode.
- runCycles_i  in  RUN_W  number of core cycles to run.
- loadValid_i  in  1  load word valid.
- loadAddress_i  in  ADDR_W  explicit write address.
- loadInstr_i  in  INSTR_W  instruction word.
- loadLast_i  in  1  marks the final load word.
- loadReady_o  out  1  load word can be accepted.
- icacheWriteEnable_o  out  1  icache write strobe.
- writeAddress_o  out  ADDR_W  icache write address.
- instruction_o  out  INSTR_W  icache write data.
- coreReset_o  out  1  core reset, active-high.
- coreEnable_o  out  1  core clock enable.
- done_o  out  1  run complete.
- wrapErr_o  out  1  sticky auto-increment address wrap.
- wordsLoaded_o  out  ADDR_W+1  words written this session.
- cycleCount_o  out  RUN_W  core cycles elapsed this run.

Function
REQ-004 SHALL implement the states IDLE, LOAD, CORE_RST, RUN and DONE.
REQ-005 IDLE: coreReset_o=1, coreEnable_o=0, loadReady_o=0. start_i moves to LOAD and latches autoInc_i, baseAddress_i and runCycles_i.
REQ-006 LOAD: loadReady_o=1. A word is accepted on a cycle with loadValid_i & loadReady_o.
REQ-007 An accepted word SHALL drive icacheWriteEnable_o=1 exactly one cycle later, with the registered address and data. Outside that cycle icacheWriteEnable_o=0.
REQ-008 Write address SHALL be loadAddress_i when autoInc=0, and baseAddress + wordsLoaded (modulo 2^ADDR_W) when autoInc=1.
REQ-009 In autoInc mode, a write whose address wraps from 2^ADDR_W-1 to 0 SHALL still be performed and SHALL set wrapErr_o, which stays set until the next start_i or reset.
REQ-010 Accepting a word with loadLast_i=1 SHALL move to CORE_RST on the next cycle. loadReady_o SHALL be 0 from that cycle onward.
REQ-011 CORE_RST: coreReset_o=1 for exactly RST_LEN cycles, then move to RUN.
REQ-012 RUN: coreReset_o=0 and coreEnable_o=1. cycleCount_o increments by 1 each cycle.
REQ-013 RUN SHALL move to DONE when cycleCount_o == runCycles-1. With runCycles=0, CORE_RST SHALL go straight to DONE and coreEnable_o SHALL never assert.
REQ-014 DONE: done_o=1, coreEnable_o=0, coreReset_o=0 (core state preserved). cycleCount_o holds its final value.
REQ-015 start_i in DONE SHALL clear wordsLoaded_o, cycleCount_o and wrapErr_o, re-latch the configuration, and enter LOAD. start_i in LOAD, CORE_RST or RUN SHALL be ignored.
REQ-016 abort_i in any state SHALL enter IDLE on the next cycle and takes priority over start_i. A write already registered (REQ-007) SHALL still complete.
REQ-017 wordsLoaded_o SHALL saturate at 2^ADDR_W.

Reset
REQ-018 On reset_i: state=IDLE; coreReset_o=1; all other outputs 0.
REQ-019 reset_i asserted during any state SHALL override abort_i and start_i and SHALL cancel any pending icache write.

Structure
REQ-020 A shared package pa_boot_pkg SHALL hold the state encoding and the default parameter values.
REQ-021 The run-cycle counter with terminal-count compare SHALL be a sub-module named boot_run_counter. All other logic SHALL reside in core_boot_ctrl.

Verification
REQ-022 The bench SHALL cover these scenarios:
- autoInc=1, base=5, 3 words (last on 3rd), runCycles=4 -> writes to addresses 5,6,7, each one cycle after acceptance; coreReset_o high 2 cycles; coreEnable_o high 4 cycles; done_o=1; wordsLoaded_o=3.
- autoInc=0, addresses 13,17,21 with loadValid_i gaps -> exactly 3 write strobes at 13,17,21; no strobes in the gap cycles.
- autoInc=1, base=0xFFFF, 2 words -> writes at 0xFFFF then 0x0000; wrapErr_o=1 after the second write.
- runCycles=0 -> CORE_RST goes to DONE; coreEnable_o never asserts; cycleCount_o=0.
- abort_i together with start_i in mid-RUN -> IDLE next cycle, coreEnable_o=0, coreReset_o=1; start_i ignored.
- reset_i on the cycle after an acceptance -> no icacheWriteEnable_o pulse; all outputs at REQ-018 values.

Source files
------------

// File: rtl/pa_boot_pkg.sv
// Shared state encoding and default parameter values for the core boot controller.
package pa_boot_pkg;

    localparam int unsigned BOOT_ADDR_W  = 16;
    localparam int unsigned BOOT_INSTR_W = 60;
    localparam int unsigned BOOT_RUN_W   = 16;
    localparam int unsigned BOOT_RST_LEN = 2;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_CORE_RST = 3'd2,
        ST_RUN      = 3'd3,
        ST_DONE     = 3'd4
    } boot_state_e;

endpackage

// File: rtl/boot_run_counter.sv
// Run-cycle counter with terminal-count compare against the latched run length.
module boot_run_counter #(
    parameter int unsigned RUN_W = 16
) (
    input  logic             clock_i,
    input  logic             reset_i,
    input  logic             clear_i,
    input  logic             enable_i,
    input  logic [RUN_W-1:0] terminal_i,
    output logic [RUN_W-1:0] count_o,
    output logic             tc_o
);

    logic [RUN_W-1:0] count_q;
    logic [RUN_W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (clear_i) begin
            count_d = '0;
        end else if (enable_i) begin
            count_d = count_q + RUN_W'(1);
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;
    // Fires on the last enabled cycle, so the count settles at the full run length.
    assign tc_o    = (count_q == (terminal_i - RUN_W'(1)));

endmodule

// File: rtl/core_boot_ctrl.sv
// Boot controller: loads instruction words into the icache, pulses core reset,
// then runs the core for a programmed number of cycles.
module core_boot_ctrl
    import pa_boot_pkg::*;
#(
    parameter int unsigned ADDR_W  = BOOT_ADDR_W,
    parameter int unsigned INSTR_W = BOOT_INSTR_W,
    parameter int unsigned RUN_W   = BOOT_RUN_W,
    parameter int unsigned RST_LEN = BOOT_RST_LEN
) (
    input  logic               clock_i,
    input  logic               reset_i,
    input  logic               start_i,
    input  logic               abort_i,
    input  logic               autoInc_i,
    input  logic [ADDR_W-1:0]  baseAddress_i,
    input  logic [RUN_W-1:0]   runCycles_i,
    input  logic               loadValid_i,
    input  logic [ADDR_W-1:0]  loadAddress_i,
    input  logic [INSTR_W-1:0] loadInstr_i,
    input  logic               loadLast_i,
    output logic               loadReady_o,
    output logic               icacheWriteEnable_o,
    output logic [ADDR_W-1:0]  writeAddress_o,
    output logic [INSTR_W-1:0] instruction_o,
    output logic               coreReset_o,
    output logic               coreEnable_o,
    output logic               done_o,
    output logic               wrapErr_o,
    output logic [ADDR_W:0]    wordsLoaded_o,
    output logic [RUN_W-1:0]   cycleCount_o
);

    localparam int unsigned     RST_CNT_W = (RST_LEN > 1) ? $clog2(RST_LEN) : 1;
    localparam logic [ADDR_W:0] WORDS_MAX = {1'b1, {ADDR_W{1'b0}}};

    boot_state_e            state_q, state_d;
    logic                   auto_inc_q, auto_inc_d;
    logic [ADDR_W-1:0]      base_q, base_d;
    logic [RUN_W-1:0]       run_cycles_q, run_cycles_d;
    logic [RST_CNT_W-1:0]   rst_cnt_q, rst_cnt_d;
    logic                   wr_en_q, wr_en_d;
    logic [ADDR_W-1:0]      wr_addr_q, wr_addr_d;
    logic [INSTR_W-1:0]     wr_data_q, wr_data_d;
    logic [ADDR_W:0]        words_q, words_d;
    logic                   wrap_q, wrap_d;

    logic                   accept;
    logic                   start_session;
    logic                   cnt_clear;
    logic                   run_tc;
    logic [ADDR_W:0]        addr_sum;

    assign accept        = (state_q == ST_LOAD) && loadValid_i;
    assign start_session = start_i && !abort_i && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    // Carry out of this sum is exactly the wrap from the top address back to zero.
    assign addr_sum      = {1'b0, base_q} + words_q;

    always_comb begin
        state_d      = state_q;
        auto_inc_d   = auto_inc_q;
        base_d       = base_q;
        run_cycles_d = run_cycles_q;
        rst_cnt_d    = rst_cnt_q;
        wr_en_d      = 1'b0;
        wr_addr_d    = wr_addr_q;
        wr_data_d    = wr_data_q;
        words_d      = words_q;
        wrap_d       = wrap_q;
        cnt_clear    = 1'b0;

        if (accept) begin
            wr_en_d   = 1'b1;
            wr_addr_d = auto_inc_q ? addr_sum[ADDR_W-1:0] : loadAddress_i;
            wr_data_d = loadInstr_i;
            if (words_q != WORDS_MAX) begin
                words_d = words_q + {{ADDR_W{1'b0}}, 1'b1};
            end
            if (auto_inc_q && addr_sum[ADDR_W]) begin
                wrap_d = 1'b1;
            end
        end

        if (start_session) begin
            auto_inc_d   = autoInc_i;
            base_d       = baseAddress_i;
            run_cycles_d = runCycles_i;
            words_d      = '0;
            wrap_d       = 1'b0;
            cnt_clear    = 1'b1;
        end

        case (state_q)
            ST_IDLE: begin
                if (start_session) state_d = ST_LOAD;
            end
            ST_LOAD: begin
                if (accept && loadLast_i) begin
                    state_d   = ST_CORE_RST;
                    rst_cnt_d = '0;
                end
            end
            ST_CORE_RST: begin
                if (rst_cnt_q == RST_CNT_W'(RST_LEN - 1)) begin
                    state_d = (run_cycles_q == '0) ? ST_DONE : ST_RUN;
                end else begin
                    rst_cnt_d = rst_cnt_q + RST_CNT_W'(1);
                end
            end
            ST_RUN: begin
                if (run_tc) state_d = ST_DONE;
            end
            ST_DONE: begin
                if (start_session) state_d = ST_LOAD;
            end
            default: state_d = ST_IDLE;
        endcase

        if (abort_i) begin
            state_d = ST_IDLE;
        end
    end

    always_ff @(posedge clock_i) begin
        if (reset_i) begin
            state_q      <= ST_IDLE;
            auto_inc_q   <= 1'b0;
            base_q       <= '0;
            run_cycles_q <= '0;
            rst_cnt_q    <= '0;
            wr_en_q      <= 1'b0;
            wr_addr_q    <= '0;
            wr_data_q    <= '0;
            words_q      <= '0;
            wrap_q       <= 1'b0;
        end else begin
            state_q      <= state_d;
            auto_inc_q   <= auto_inc_d;
            base_q       <= base_d;
            run_cycles_q <= run_cycles_d;
            rst_cnt_q    <= rst_cnt_d;
            wr_en_q      <= wr_en_d;
            wr_addr_q    <= wr_addr_d;
            wr_data_q    <= wr_data_d;
            words_q      <= words_d;
            wrap_q       <= wrap_d;
        end
    end

    boot_run_counter #(
        .RUN_W (RUN_W)
    ) u_run_counter (
        .clock_i    (clock_i),
        .reset_i    (reset_i),
        .clear_i    (cnt_clear),
        .enable_i   (state_q == ST_RUN),
        .terminal_i (run_cycles_q),
        .count_o    (cycleCount_o),
        .tc_o       (run_tc)
    );

    assign loadReady_o         = (state_q == ST_LOAD);
    // Gating with reset_i lets a reset in the strobe cycle cancel the pending write.
    assign icacheWriteEnable_o = wr_en_q && !reset_i;
    assign writeAddress_o      = wr_addr_q;
    assign instruction_o       = wr_data_q;
    assign coreReset_o         = (state_q == ST_IDLE) || (state_q == ST_LOAD) || (state_q == ST_CORE_RST);
    assign coreEnable_o        = (state_q == ST_RUN);
    assign done_o              = (state_q == ST_DONE);
    assign wrapErr_o           = wrap_q;
    assign wordsLoaded_o       = words_q;

endmodule

// File: tb/tb_core_boot_ctrl.sv
// Directed bench for core_boot_ctrl: one task per scenario, inline comparisons.
module tb_core_boot_ctrl;

    localparam int unsigned ADDR_W  = 16;
    localparam int unsigned INSTR_W = 60;
    localparam int unsigned RUN_W   = 16;

    logic               clock_i = 1'b0;
    logic               reset_i = 1'b1;
    logic               start_i = 1'b0;
    logic               abort_i = 1'b0;
    logic               autoInc_i = 1'b0;
    logic [ADDR_W-1:0]  baseAddress_i = '0;
    logic [RUN_W-1:0]   runCycles_i = '0;
    logic               loadValid_i = 1'b0;
    logic [ADDR_W-1:0]  loadAddress_i = '0;
    logic [INSTR_W-1:0] loadInstr_i = '0;
    logic               loadLast_i = 1'b0;
    logic               loadReady_o;
    logic               icacheWriteEnable_o;
    logic [ADDR_W-1:0]  writeAddress_o;
    logic [INSTR_W-1:0] instruction_o;
    logic               coreReset_o;
    logic               coreEnable_o;
    logic               done_o;
    logic               wrapErr_o;
    logic [ADDR_W:0]    wordsLoaded_o;
    logic [RUN_W-1:0]   cycleCount_o;

    int checks = 0;
    int errors = 0;

    core_boot_ctrl #(
        .ADDR_W  (ADDR_W),
        .INSTR_W (INSTR_W),
        .RUN_W   (RUN_W),
        .RST_LEN (2)
    ) dut (
        .clock_i             (clock_i),
        .reset_i             (reset_i),
        .start_i             (start_i),
        .abort_i             (abort_i),
        .autoInc_i           (autoInc_i),
        .baseAddress_i       (baseAddress_i),
        .runCycles_i         (runCycles_i),
        .loadValid_i         (loadValid_i),
        .loadAddress_i       (loadAddress_i),
        .loadInstr_i         (loadInstr_i),
        .loadLast_i          (loadLast_i),
        .loadReady_o         (loadReady_o),
        .icacheWriteEnable_o (icacheWriteEnable_o),
        .writeAddress_o      (writeAddress_o),
        .instruction_o       (instruction_o),
        .coreReset_o         (coreReset_o),
        .coreEnable_o        (coreEnable_o),
        .done_o              (done_o),
        .wrapErr_o           (wrapErr_o),
        .wordsLoaded_o       (wordsLoaded_o),
        .cycleCount_o        (cycleCount_o)
    );

    always #5 clock_i = ~clock_i;

    task automatic tick;
        @(posedge clock_i);
        #1;
    endtask

    function automatic logic [INSTR_W-1:0] instr_of(input logic [ADDR_W-1:0] a);
        return 60'h0A5_A5A5_0000_0000 | {{(INSTR_W-ADDR_W){1'b0}}, a};
    endfunction

    task automatic start_session(input logic ai, input logic [ADDR_W-1:0] base,
                                 input logic [RUN_W-1:0] runc);
        start_i = 1'b1; autoInc_i = ai; baseAddress_i = base; runCycles_i = runc;
        tick;
        start_i = 1'b0;
    endtask

    // Drives one load word for a cycle; outputs afterwards show the write strobe cycle.
    task automatic load_word(input logic [ADDR_W-1:0] addr, input logic last);
        loadValid_i = 1'b1; loadAddress_i = addr; loadInstr_i = instr_of(addr); loadLast_i = last;
        tick;
        loadValid_i = 1'b0; loadLast_i = 1'b0;
    endtask

    // Runs from CORE_RST entry to DONE, counting reset and enable cycles (bounded).
    task automatic wait_done(output int rst_cyc, output int en_cyc);
        int n;
        rst_cyc = 0; en_cyc = 0; n = 0;
        while (!done_o && n < 100) begin
            if (coreReset_o) rst_cyc++;
            if (coreEnable_o) en_cyc++;
            tick;
            n++;
        end
        checks++;
        if (done_o !== 1'b1) begin
            errors++; $display("FAIL wait_done timeout done=%b exp 1", done_o);
        end
    endtask

    task automatic test_reset;
        reset_i = 1'b1;
        tick; tick;
        checks++;
        if ({coreReset_o, coreEnable_o, loadReady_o, icacheWriteEnable_o, done_o, wrapErr_o} !== 6'b100000) begin
            errors++; $display("FAIL reset_ctrl got %b exp 100000",
                {coreReset_o, coreEnable_o, loadReady_o, icacheWriteEnable_o, done_o, wrapErr_o});
        end
        checks++;
        if (writeAddress_o !== '0 || instruction_o !== '0 || wordsLoaded_o !== '0 || cycleCount_o !== '0) begin
            errors++; $display("FAIL reset_data addr=%0h instr=%0h words=%0d cyc=%0d exp 0",
                writeAddress_o, instruction_o, wordsLoaded_o, cycleCount_o);
        end
        reset_i = 1'b0;
        tick;
    endtask

    task automatic test_autoinc;
        int rc, ec;
        start_session(1'b1, 16'd5, 16'd4);
        checks++;
        if (loadReady_o !== 1'b1 || coreReset_o !== 1'b1) begin
            errors++; $display("FAIL auto_load_state ready=%b rst=%b exp 1 1", loadReady_o, coreReset_o);
        end
        for (int i = 0; i < 3; i++) begin
            load_word(16'h0100 + 16'(i), (i == 2));
            checks++;
            if (icacheWriteEnable_o !== 1'b1 || writeAddress_o !== 16'(5 + i) || instruction_o !== instr_of(16'h0100 + 16'(i))) begin
                errors++; $display("FAIL auto_write%0d we=%b addr=%0d data=%0h exp 1 %0d %0h", i,
                    icacheWriteEnable_o, writeAddress_o, instruction_o, 5 + i, instr_of(16'h0100 + 16'(i)));
            end
        end
        checks++;
        if (loadReady_o !== 1'b0) begin
            errors++; $display("FAIL auto_ready_after_last got %b exp 0", loadReady_o);
        end
        wait_done(rc, ec);
        checks++;
        if (rc != 2 || ec != 4) begin
            errors++; $display("FAIL auto_rst_en_cycles rst=%0d en=%0d exp 2 4", rc, ec);
        end
        checks++;
        if (wordsLoaded_o !== 17'd3 || cycleCount_o !== 16'd4 || coreReset_o !== 1'b0 || coreEnable_o !== 1'b0) begin
            errors++; $display("FAIL auto_done words=%0d cyc=%0d rst=%b en=%b exp 3 4 0 0",
                wordsLoaded_o, cycleCount_o, coreReset_o, coreEnable_o);
        end
    endtask

    task automatic test_explicit_gaps;
        logic [5:0]  pat;
        logic [15:0] addrs [6];
        int rc, ec, strobes;
        pat = 6'b101001;
        addrs = '{16'd13, 16'd99, 16'd98, 16'd17, 16'd97, 16'd21};
        strobes = 0;
        start_session(1'b0, 16'd0, 16'd1);
        checks++;
        if (wordsLoaded_o !== '0) begin
            errors++; $display("FAIL expl_words_cleared got %0d exp 0", wordsLoaded_o);
        end
        for (int i = 0; i < 6; i++) begin
            loadValid_i = pat[i]; loadAddress_i = addrs[i]; loadInstr_i = instr_of(addrs[i]);
            loadLast_i = (i == 5);
            tick;
            loadValid_i = 1'b0; loadLast_i = 1'b0;
            if (icacheWriteEnable_o) strobes++;
            checks++;
            if (icacheWriteEnable_o !== pat[i] || (pat[i] && writeAddress_o !== addrs[i])) begin
                errors++; $display("FAIL expl_cycle%0d we=%b addr=%0d exp %b %0d", i,
                    icacheWriteEnable_o, writeAddress_o, pat[i], addrs[i]);
            end
        end
        wait_done(rc, ec);
        checks++;
        if (strobes != 3 || wordsLoaded_o !== 17'd3 || ec != 1) begin
            errors++; $display("FAIL expl_summary strobes=%0d words=%0d en=%0d exp 3 3 1", strobes, wordsLoaded_o, ec);
        end
    endtask

    task automatic test_wrap;
        int rc, ec;
        start_session(1'b1, 16'hFFFF, 16'd1);
        load_word(16'h0, 1'b0);
        checks++;
        if (icacheWriteEnable_o !== 1'b1 || writeAddress_o !== 16'hFFFF || wrapErr_o !== 1'b0) begin
            errors++; $display("FAIL wrap_first we=%b addr=%0h err=%b exp 1 ffff 0", icacheWriteEnable_o, writeAddress_o, wrapErr_o);
        end
        load_word(16'h0, 1'b1);
        checks++;
        if (icacheWriteEnable_o !== 1'b1 || writeAddress_o !== 16'h0000 || wrapErr_o !== 1'b1) begin
            errors++; $display("FAIL wrap_second we=%b addr=%0h err=%b exp 1 0 1", icacheWriteEnable_o, writeAddress_o, wrapErr_o);
        end
        wait_done(rc, ec);
        checks++;
        if (wrapErr_o !== 1'b1) begin
            errors++; $display("FAIL wrap_sticky got %b exp 1", wrapErr_o);
        end
    endtask

    task automatic test_zero_run;
        int rc, ec;
        start_session(1'b1, 16'd40, 16'd0);
        checks++;
        if (wrapErr_o !== 1'b0 || cycleCount_o !== '0) begin
            errors++; $display("FAIL zero_restart_clear err=%b cyc=%0d exp 0 0", wrapErr_o, cycleCount_o);
        end
        load_word(16'h0, 1'b1);
        wait_done(rc, ec);
        checks++;
        if (rc != 2 || ec != 0 || cycleCount_o !== '0) begin
            errors++; $display("FAIL zero_run rst=%0d en=%0d cyc=%0d exp 2 0 0", rc, ec, cycleCount_o);
        end
    endtask

    task automatic test_abort_run;
        int n;
        start_session(1'b1, 16'd0, 16'd10);
        load_word(16'h0, 1'b1);
        n = 0;
        while (!coreEnable_o && n < 20) begin tick; n++; end
        checks++;
        if (coreEnable_o !== 1'b1) begin
            errors++; $display("FAIL abort_reach_run en=%b exp 1", coreEnable_o);
        end
        tick; tick;
        abort_i = 1'b1; start_i = 1'b1;
        tick;
        abort_i = 1'b0; start_i = 1'b0;
        checks++;
        if (coreEnable_o !== 1'b0 || coreReset_o !== 1'b1 || loadReady_o !== 1'b0 || done_o !== 1'b0) begin
            errors++; $display("FAIL abort_idle en=%b rst=%b ready=%b done=%b exp 0 1 0 0",
                coreEnable_o, coreReset_o, loadReady_o, done_o);
        end
        tick;
        checks++;
        if (loadReady_o !== 1'b0) begin
            errors++; $display("FAIL abort_start_ignored ready=%b exp 0", loadReady_o);
        end
    endtask

    task automatic test_reset_cancel;
        start_session(1'b0, 16'd0, 16'd3);
        load_word(16'd55, 1'b0);
        reset_i = 1'b1;
        #1;
        checks++;
        if (icacheWriteEnable_o !== 1'b0) begin
            errors++; $display("FAIL rstcancel_strobe got %b exp 0", icacheWriteEnable_o);
        end
        tick;
        reset_i = 1'b0;
        checks++;
        if ({coreReset_o, coreEnable_o, loadReady_o, icacheWriteEnable_o, done_o, wrapErr_o} !== 6'b100000 ||
            writeAddress_o !== '0 || instruction_o !== '0 || wordsLoaded_o !== '0) begin
            errors++; $display("FAIL rstcancel_outputs ctrl=%b addr=%0h instr=%0h words=%0d exp 100000 0 0 0",
                {coreReset_o, coreEnable_o, loadReady_o, icacheWriteEnable_o, done_o, wrapErr_o},
                writeAddress_o, instruction_o, wordsLoaded_o);
        end
        tick;
        checks++;
        if (icacheWriteEnable_o !== 1'b0) begin
            errors++; $display("FAIL rstcancel_late_strobe got %b exp 0", icacheWriteEnable_o);
        end
    endtask

    initial begin
        test_reset;
        test_autoinc;
        test_explicit_gaps;
        test_wrap;
        test_zero_run;
        test_abort_run;
        test_reset_cancel;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
